// File: rtl/agu_dcache_arbiter_pkg.sv
// Shared types and default sizes for the AGU <-> dcache port arbiter.
package agu_dcache_arbiter_pkg;

  localparam int W_REG          = 7;
  localparam int W_BRM          = 4;
  localparam int W_MEM          = 4;
  localparam int W_DATA         = 32;
  localparam int STARVE_MAX_DEF = 4;
  localparam int MAX_RETRY_DEF  = 7;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LD_WAIT = 2'd1,
    ST_WAIT = 2'd2,
    REPLAY  = 2'd3
  } state_t;

  typedef struct packed {
    logic              is_st;
    logic [W_MEM-1:0]  addr;
    logic [W_DATA-1:0] data;
    logic [W_REG-1:0]  rd;
    logic [W_BRM-1:0]  brmask;
  } req_t;

endpackage

// File: rtl/agu_dcache_arbiter_if.sv
// Load/store request, dcache and write-back signals of the arbiter, bundled.
interface agu_dcache_arbiter_if;
  import agu_dcache_arbiter_pkg::*;

  logic              i_ld_val;
  logic [W_MEM-1:0]  i_ld_addr;
  logic [W_REG-1:0]  i_ld_rd;
  logic [W_BRM-1:0]  i_ld_brmask;
  logic              o_ld_rdy;
  logic              i_st_val;
  logic [W_MEM-1:0]  i_st_addr;
  logic [W_DATA-1:0] i_st_data;
  logic              o_st_rdy;
  logic [W_BRM-1:0]  i_brkill;
  logic [W_MEM-1:0]  dcache_i_addr;
  logic [W_DATA-1:0] dcache_i_data;
  logic              dcache_i_we;
  logic              dcache_i_kill;
  logic [W_DATA-1:0] dcache_o_data;
  logic              dcache_o_nack;
  logic              o_val;
  logic [W_DATA-1:0] o_data;
  logic [W_REG-1:0]  o_addr;
  logic              o_exc;

  modport slave (
    input  i_ld_val, i_ld_addr, i_ld_rd, i_ld_brmask, i_st_val, i_st_addr, i_st_data,
           i_brkill, dcache_o_data, dcache_o_nack,
    output o_ld_rdy, o_st_rdy, dcache_i_addr, dcache_i_data, dcache_i_we, dcache_i_kill,
           o_val, o_data, o_addr, o_exc
  );

  modport master (
    output i_ld_val, i_ld_addr, i_ld_rd, i_ld_brmask, i_st_val, i_st_addr, i_st_data,
           i_brkill, dcache_o_data, dcache_o_nack,
    input  o_ld_rdy, o_st_rdy, dcache_i_addr, dcache_i_data, dcache_i_we, dcache_i_kill,
           o_val, o_data, o_addr, o_exc
  );

endinterface

// File: rtl/agu_dcache_arbiter_starve_cnt.sv
// Saturating cycle counter; o_sat flags that the count has reached MAX.
module agu_starve_cnt #(
  parameter int MAX = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_sat
);
  localparam int W = $clog2(MAX + 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign o_sat = (cnt_q == W'(MAX));

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr)
      cnt_d = '0;
    else if (i_inc && !o_sat)
      cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/agu_dcache_arbiter.sv
// Shares one dcache port between the LAQ head and the committed SAQ head, one access in flight.
// state   | meaning
// IDLE    | no access outstanding, may grant
// LD_WAIT | load response cycle: kill, nack or write back (and re-grant)
// ST_WAIT | store response cycle: nack or done (and re-grant)
// REPLAY  | reissue the latched access after a nack
module agu_dcache_arbiter
  import agu_dcache_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int MAX_RETRY  = MAX_RETRY_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  agu_dcache_arbiter_if.slave bus
);
  localparam int RW = $clog2(MAX_RETRY + 1);

  state_t            state_q, state_d;
  req_t              req_q, req_d;
  logic [RW-1:0]     retry_q, retry_d, retry_inc;
  logic              st_sat, can_grant, ld_ok, grant_ld, grant_st, kill_hit;
  logic              ld_rdy, st_rdy, c_we, c_kill, wb_val, exc;
  logic [W_MEM-1:0]  c_addr;
  logic [W_DATA-1:0] c_data, wb_data;
  logic [W_REG-1:0]  wb_addr;

  agu_starve_cnt #(.MAX(STARVE_MAX)) u_st_age (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (bus.i_st_val & ~grant_st),
    .i_clr   (grant_st),
    .o_sat   (st_sat)
  );

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    retry_d   = retry_q;
    retry_inc = retry_q + RW'(1);
    kill_hit  = (req_q.brmask & bus.i_brkill) != '0;
    can_grant = 1'b0;
    ld_ok     = 1'b0;
    grant_ld  = 1'b0;
    grant_st  = 1'b0;
    ld_rdy    = 1'b0;
    st_rdy    = 1'b0;
    c_addr    = '0;
    c_data    = '0;
    c_we      = 1'b0;
    c_kill    = 1'b0;
    wb_val    = 1'b0;
    wb_data   = '0;
    wb_addr   = '0;
    exc       = 1'b0;

    unique case (state_q)
      IDLE: can_grant = 1'b1;
      LD_WAIT, ST_WAIT: begin
        // committed stores are never killed, so kill_hit only matters for loads
        if (state_q == LD_WAIT && kill_hit) begin
          c_kill  = 1'b1;
          state_d = IDLE;
        end else if (bus.dcache_o_nack) begin
          retry_d = retry_inc;
          if (retry_inc == RW'(MAX_RETRY)) begin
            exc     = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = REPLAY;
          end
        end else begin
          wb_val    = (state_q == LD_WAIT);
          wb_data   = (state_q == LD_WAIT) ? bus.dcache_o_data : '0;
          wb_addr   = (state_q == LD_WAIT) ? req_q.rd : '0;
          can_grant = 1'b1;
          state_d   = IDLE;
        end
      end
      REPLAY: begin
        c_addr  = req_q.addr;
        c_data  = req_q.is_st ? req_q.data : '0;
        c_we    = req_q.is_st;
        state_d = req_q.is_st ? ST_WAIT : LD_WAIT;
      end
      default: state_d = IDLE;
    endcase

    if (can_grant) begin
      ld_ok = bus.i_ld_val && ((bus.i_ld_brmask & bus.i_brkill) == '0);
      if (bus.i_st_val && (st_sat || !ld_ok))
        grant_st = 1'b1;
      else if (ld_ok)
        grant_ld = 1'b1;
    end

    if (grant_ld) begin
      ld_rdy  = 1'b1;
      c_addr  = bus.i_ld_addr;
      req_d   = '{is_st: 1'b0, addr: bus.i_ld_addr, data: '0, rd: bus.i_ld_rd, brmask: bus.i_ld_brmask};
      retry_d = '0;
      state_d = LD_WAIT;
    end else if (grant_st) begin
      st_rdy  = 1'b1;
      c_addr  = bus.i_st_addr;
      c_data  = bus.i_st_data;
      c_we    = 1'b1;
      req_d   = '{is_st: 1'b1, addr: bus.i_st_addr, data: bus.i_st_data, rd: '0, brmask: '0};
      retry_d = '0;
      state_d = ST_WAIT;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      req_q   <= '0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      retry_q <= retry_d;
    end
  end

  // outputs held quiet while reset is asserted, even mid-access
  assign bus.o_ld_rdy      = i_rst_n & ld_rdy;
  assign bus.o_st_rdy      = i_rst_n & st_rdy;
  assign bus.dcache_i_we   = i_rst_n & c_we;
  assign bus.dcache_i_kill = i_rst_n & c_kill;
  assign bus.o_val         = i_rst_n & wb_val;
  assign bus.o_exc         = i_rst_n & exc;
  assign bus.dcache_i_addr = i_rst_n ? c_addr : '0;
  assign bus.dcache_i_data = i_rst_n ? c_data : '0;
  assign bus.o_data        = i_rst_n ? wb_data : '0;
  assign bus.o_addr        = i_rst_n ? wb_addr : '0;

endmodule

// File: tb/tb_agu_dcache_arbiter.sv
// Bench for agu_dcache_arbiter: directed cycle table, hand sequences, randomized model check.
module tb_agu_dcache_arbiter;
  localparam int STARVE_MAX = 4;
  localparam int MAX_RETRY  = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  agu_dcache_arbiter_if bus();

  agu_dcache_arbiter #(.STARVE_MAX(STARVE_MAX), .MAX_RETRY(MAX_RETRY)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  // dcache model: sync-read RAM, reloaded with a known pattern during reset
  logic [31:0] ram [16];
  logic [31:0] rdata;

  function automatic logic [31:0] init_word(input int i);
    return (i == 3) ? 32'h0000_A5A5 : 32'h1000_0000 + 32'(i);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) ram[i] <= init_word(i);
      rdata <= '0;
    end else begin
      if (bus.dcache_i_we) ram[bus.dcache_i_addr] <= bus.dcache_i_data;
      rdata <= ram[bus.dcache_i_addr];
    end
  end
  assign bus.dcache_o_data = rdata;

  typedef struct packed {
    logic        lv;  logic [3:0] la;  logic [6:0] lr;  logic [3:0] lm;
    logic        sv;  logic [3:0] sa;  logic [31:0] sd;
    logic [3:0]  bk;  logic nk;
    logic        e_lr; logic e_sr; logic e_we; logic [31:0] e_wd; logic e_kl;
    logic        e_v;  logic [31:0] e_d; logic [6:0] e_a; logic e_x;
    logic        e_is; logic [3:0] e_da;
  } vec_t;

  vec_t tbl[$];
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic lv, input logic [3:0] la, input logic [6:0] lr, input logic [3:0] lm,
                        input logic sv, input logic [3:0] sa, input logic [31:0] sd,
                        input logic [3:0] bk, input logic nk);
    bus.i_ld_val = lv; bus.i_ld_addr = la; bus.i_ld_rd = lr; bus.i_ld_brmask = lm;
    bus.i_st_val = sv; bus.i_st_addr = sa; bus.i_st_data = sd;
    bus.i_brkill = bk; bus.dcache_o_nack = nk;
  endtask

  task automatic idle_in();
    set_in(1'b0, 4'd0, 7'd0, 4'd0, 1'b0, 4'd0, 32'd0, 4'd0, 1'b0);
  endtask

  task automatic to_drive();
    @(posedge clk); #1;
  endtask

  task automatic to_sample();
    @(negedge clk);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".ld_rdy"}, 32'(bus.o_ld_rdy), 32'd0);
    chk({tag, ".st_rdy"}, 32'(bus.o_st_rdy), 32'd0);
    chk({tag, ".val"},    32'(bus.o_val), 32'd0);
    chk({tag, ".exc"},    32'(bus.o_exc), 32'd0);
    chk({tag, ".we"},     32'(bus.dcache_i_we), 32'd0);
    chk({tag, ".kill"},   32'(bus.dcache_i_kill), 32'd0);
    chk({tag, ".data"},   bus.o_data, 32'd0);
    chk({tag, ".addr"},   32'(bus.o_addr), 32'd0);
    chk({tag, ".daddr"},  32'(bus.dcache_i_addr), 32'd0);
    chk({tag, ".dwdata"}, bus.dcache_i_data, 32'd0);
  endtask

  // reference model state for the random phase
  logic [31:0] mm [16];
  bit          pend, p_st;
  logic [3:0]  p_addr, p_mask;
  logic [6:0]  p_rd;
  logic [31:0] p_data;
  int          p_nacks, p_due, age;

  initial begin
    idle_in();
    set_in(1'b1, 4'd1, 7'd1, 4'd0, 1'b1, 4'd2, 32'h1, 4'd0, 1'b0);
    repeat (2) begin to_drive(); to_sample(); chk_quiet("reset"); end
    to_drive(); rst_n = 1'b1; idle_in();
    to_sample(); chk_quiet("post_reset");

    tbl.push_back(vec_t'{lv:1'b1, la:4'd3, lr:7'd2, e_lr:1'b1, e_is:1'b1, e_da:4'd3, default:'0});
    tbl.push_back(vec_t'{e_v:1'b1, e_d:32'h0000_A5A5, e_a:7'd2, default:'0});
    tbl.push_back(vec_t'{default:'0});
    tbl.push_back(vec_t'{lv:1'b1, la:4'd1, lr:7'd10, sv:1'b1, sa:4'd7, sd:32'hDEAD_0007, e_lr:1'b1, e_is:1'b1, e_da:4'd1, default:'0});
    tbl.push_back(vec_t'{lv:1'b1, la:4'd2, lr:7'd11, sv:1'b1, sa:4'd7, sd:32'hDEAD_0007, e_lr:1'b1, e_is:1'b1, e_da:4'd2, e_v:1'b1, e_d:32'h1000_0001, e_a:7'd10, default:'0});
    tbl.push_back(vec_t'{lv:1'b1, la:4'd4, lr:7'd12, sv:1'b1, sa:4'd7, sd:32'hDEAD_0007, e_lr:1'b1, e_is:1'b1, e_da:4'd4, e_v:1'b1, e_d:32'h1000_0002, e_a:7'd11, default:'0});
    tbl.push_back(vec_t'{lv:1'b1, la:4'd6, lr:7'd13, sv:1'b1, sa:4'd7, sd:32'hDEAD_0007, e_lr:1'b1, e_is:1'b1, e_da:4'd6, e_v:1'b1, e_d:32'h1000_0004, e_a:7'd12, default:'0});
    tbl.push_back(vec_t'{lv:1'b1, la:4'd8, lr:7'd14, sv:1'b1, sa:4'd7, sd:32'hDEAD_0007, e_sr:1'b1, e_we:1'b1, e_wd:32'hDEAD_0007, e_is:1'b1, e_da:4'd7, e_v:1'b1, e_d:32'h1000_0006, e_a:7'd13, default:'0});
    tbl.push_back(vec_t'{lv:1'b1, la:4'd8, lr:7'd14, e_lr:1'b1, e_is:1'b1, e_da:4'd8, default:'0});
    tbl.push_back(vec_t'{e_v:1'b1, e_d:32'h1000_0008, e_a:7'd14, default:'0});
    tbl.push_back(vec_t'{lv:1'b1, la:4'd7, lr:7'd15, sv:1'b1, sa:4'd9, sd:32'h0000_9999, e_lr:1'b1, e_is:1'b1, e_da:4'd7, default:'0});
    tbl.push_back(vec_t'{sv:1'b1, sa:4'd9, sd:32'h0000_9999, e_sr:1'b1, e_we:1'b1, e_wd:32'h0000_9999, e_is:1'b1, e_da:4'd9, e_v:1'b1, e_d:32'hDEAD_0007, e_a:7'd15, default:'0});
    tbl.push_back(vec_t'{default:'0});
    tbl.push_back(vec_t'{lv:1'b1, la:4'd2, lr:7'd3, lm:4'h2, e_lr:1'b1, e_is:1'b1, e_da:4'd2, default:'0});
    tbl.push_back(vec_t'{lv:1'b1, la:4'd4, lr:7'd4, bk:4'h2, e_kl:1'b1, default:'0});
    tbl.push_back(vec_t'{lv:1'b1, la:4'd4, lr:7'd4, e_lr:1'b1, e_is:1'b1, e_da:4'd4, default:'0});
    tbl.push_back(vec_t'{e_v:1'b1, e_d:32'h1000_0004, e_a:7'd4, default:'0});
    tbl.push_back(vec_t'{lv:1'b1, la:4'd1, lr:7'd5, lm:4'h8, bk:4'h8, default:'0});
    tbl.push_back(vec_t'{lv:1'b1, la:4'd1, lr:7'd5, lm:4'h8, e_lr:1'b1, e_is:1'b1, e_da:4'd1, default:'0});
    tbl.push_back(vec_t'{e_v:1'b1, e_d:32'h1000_0001, e_a:7'd5, default:'0});
    tbl.push_back(vec_t'{lv:1'b1, la:4'd5, lr:7'd6, e_lr:1'b1, e_is:1'b1, e_da:4'd5, default:'0});
    tbl.push_back(vec_t'{nk:1'b1, default:'0});
    tbl.push_back(vec_t'{e_is:1'b1, e_da:4'd5, default:'0});
    tbl.push_back(vec_t'{nk:1'b1, default:'0});
    tbl.push_back(vec_t'{e_is:1'b1, e_da:4'd5, default:'0});
    tbl.push_back(vec_t'{e_v:1'b1, e_d:32'h1000_0005, e_a:7'd6, default:'0});
    tbl.push_back(vec_t'{sv:1'b1, sa:4'd10, sd:32'h0000_ABCD, e_sr:1'b1, e_we:1'b1, e_wd:32'h0000_ABCD, e_is:1'b1, e_da:4'd10, default:'0});
    tbl.push_back(vec_t'{nk:1'b1, default:'0});
    tbl.push_back(vec_t'{e_we:1'b1, e_wd:32'h0000_ABCD, e_is:1'b1, e_da:4'd10, default:'0});
    tbl.push_back(vec_t'{default:'0});
    tbl.push_back(vec_t'{lv:1'b1, la:4'd10, lr:7'd7, e_lr:1'b1, e_is:1'b1, e_da:4'd10, default:'0});
    tbl.push_back(vec_t'{e_v:1'b1, e_d:32'h0000_ABCD, e_a:7'd7, default:'0});

    foreach (tbl[i]) begin
      string t;
      t = $sformatf("row%0d", i);
      to_drive();
      set_in(tbl[i].lv, tbl[i].la, tbl[i].lr, tbl[i].lm, tbl[i].sv, tbl[i].sa, tbl[i].sd, tbl[i].bk, tbl[i].nk);
      to_sample();
      chk({t, ".ld_rdy"}, 32'(bus.o_ld_rdy), 32'(tbl[i].e_lr));
      chk({t, ".st_rdy"}, 32'(bus.o_st_rdy), 32'(tbl[i].e_sr));
      chk({t, ".we"},     32'(bus.dcache_i_we), 32'(tbl[i].e_we));
      chk({t, ".kill"},   32'(bus.dcache_i_kill), 32'(tbl[i].e_kl));
      chk({t, ".val"},    32'(bus.o_val), 32'(tbl[i].e_v));
      chk({t, ".exc"},    32'(bus.o_exc), 32'(tbl[i].e_x));
      if (tbl[i].e_v) begin
        chk({t, ".data"}, bus.o_data, tbl[i].e_d);
        chk({t, ".addr"}, 32'(bus.o_addr), 32'(tbl[i].e_a));
      end
      if (tbl[i].e_is) chk({t, ".daddr"}, 32'(bus.dcache_i_addr), 32'(tbl[i].e_da));
      if (tbl[i].e_we) chk({t, ".wdata"}, bus.dcache_i_data, tbl[i].e_wd);
    end

    // load nacked MAX_RETRY times is dropped with a single o_exc pulse
    to_drive(); set_in(1'b1, 4'd11, 7'd9, 4'd0, 1'b0, 4'd0, 32'd0, 4'd0, 1'b0);
    to_sample(); chk("retry.grant", 32'(bus.o_ld_rdy), 32'd1);
    for (int k = 1; k <= MAX_RETRY; k++) begin
      to_drive(); set_in(1'b0, 4'd0, 7'd0, 4'd0, 1'b0, 4'd0, 32'd0, 4'd0, 1'b1);
      to_sample();
      chk($sformatf("retry.val%0d", k), 32'(bus.o_val), 32'd0);
      chk($sformatf("retry.exc%0d", k), 32'(bus.o_exc), 32'(k == MAX_RETRY));
      if (k < MAX_RETRY) begin
        to_drive(); idle_in();
        to_sample();
        chk($sformatf("retry.reissue%0d", k), 32'(bus.dcache_i_addr), 32'd11);
        chk($sformatf("retry.exc_r%0d", k), 32'(bus.o_exc), 32'd0);
      end
    end
    to_drive(); set_in(1'b1, 4'd12, 7'd8, 4'd0, 1'b0, 4'd0, 32'd0, 4'd0, 1'b0);
    to_sample(); chk("retry.idle_grant", 32'(bus.o_ld_rdy), 32'd1);
    chk("retry.no_exc", 32'(bus.o_exc), 32'd0);
    to_drive(); idle_in();
    to_sample(); chk("retry.after_val", 32'(bus.o_val), 32'd1);
    chk("retry.after_data", bus.o_data, 32'h1000_000C);

    // reset while a load is in flight drops it
    to_drive(); set_in(1'b1, 4'd13, 7'd1, 4'd0, 1'b0, 4'd0, 32'd0, 4'd0, 1'b0);
    to_sample(); chk("rst.grant", 32'(bus.o_ld_rdy), 32'd1);
    to_drive(); rst_n = 1'b0; set_in(1'b1, 4'd14, 7'd2, 4'd0, 1'b1, 4'd1, 32'h5, 4'd0, 1'b0);
    to_sample(); chk_quiet("rst.in_ldwait");
    to_drive(); rst_n = 1'b1; idle_in();
    to_sample(); chk_quiet("rst.release");
    to_drive(); idle_in();
    to_sample(); chk("rst.no_val", 32'(bus.o_val), 32'd0);
    to_drive(); set_in(1'b1, 4'd13, 7'd1, 4'd0, 1'b0, 4'd0, 32'd0, 4'd0, 1'b0);
    to_sample(); chk("rst.regrant", 32'(bus.o_ld_rdy), 32'd1);
    to_drive(); idle_in();
    to_sample(); chk("rst.val", 32'(bus.o_val), 32'd1);
    chk("rst.data", bus.o_data, 32'h1000_000D);

    // randomized traffic against the timeline model
    to_drive(); rst_n = 1'b0; idle_in();
    to_drive(); rst_n = 1'b1;
    for (int i = 0; i < 16; i++) mm[i] = init_word(i);
    pend = 1'b0; p_st = 1'b0; p_addr = '0; p_mask = '0; p_rd = '0; p_data = '0;
    p_nacks = 0; p_due = 0; age = 0;
    begin
      logic lv, sv, nk, e_lr, e_sr, e_v, e_x, e_kl, e_we, can, ldok, replay_now;
      logic [3:0] la, lm, sa, bk;
      logic [6:0] lr;
      logic [31:0] sd;
      lv = 1'b0; sv = 1'b0; la = '0; lm = '0; lr = '0; sa = '0; sd = '0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        to_drive();
        if (!lv && $urandom_range(0, 3) != 0) begin
          lv = 1'b1; la = 4'($urandom); lr = 7'($urandom);
          lm = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
        end
        if (!sv && $urandom_range(0, 2) == 0) begin
          sv = 1'b1; sa = 4'($urandom); sd = $urandom;
        end
        nk = ($urandom_range(0, 3) == 0);
        bk = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'd0;
        set_in(lv, la, lr, lm, sv, sa, sd, bk, nk);
        to_sample();

        replay_now = pend && (p_nacks > 0) && (cyc == p_due - 1);
        e_lr = 1'b0; e_sr = 1'b0; e_v = 1'b0; e_x = 1'b0; e_kl = 1'b0;
        can = !pend;
        if (pend && cyc == p_due) begin
          if (!p_st && (p_mask & bk) != 4'd0) begin
            e_kl = 1'b1; pend = 1'b0;
          end else if (nk) begin
            p_nacks++;
            if (p_nacks == MAX_RETRY) begin e_x = 1'b1; pend = 1'b0; end
            else p_due = cyc + 2;
          end else begin
            e_v = !p_st; pend = 1'b0; can = 1'b1;
          end
        end
        ldok = lv && ((lm & bk) == 4'd0);
        if (can) begin
          if (sv && (age == STARVE_MAX || !ldok)) e_sr = 1'b1;
          else if (ldok) e_lr = 1'b1;
        end
        e_we = e_sr || (replay_now && p_st);

        chk("rnd.ld_rdy", 32'(bus.o_ld_rdy), 32'(e_lr));
        chk("rnd.st_rdy", 32'(bus.o_st_rdy), 32'(e_sr));
        chk("rnd.val",    32'(bus.o_val), 32'(e_v));
        chk("rnd.exc",    32'(bus.o_exc), 32'(e_x));
        chk("rnd.kill",   32'(bus.dcache_i_kill), 32'(e_kl));
        chk("rnd.we",     32'(bus.dcache_i_we), 32'(e_we));
        if (e_v) begin
          chk("rnd.data", bus.o_data, p_data);
          chk("rnd.addr", 32'(bus.o_addr), 32'(p_rd));
        end
        if (replay_now) chk("rnd.reissue", 32'(bus.dcache_i_addr), 32'(p_addr));
        if (e_sr) chk("rnd.st_daddr", 32'(bus.dcache_i_addr), 32'(sa));
        if (e_lr) chk("rnd.ld_daddr", 32'(bus.dcache_i_addr), 32'(la));

        if (e_sr) age = 0;
        else if (sv && age < STARVE_MAX) age++;
        if (e_sr) begin
          mm[sa] = sd;
          pend = 1'b1; p_st = 1'b1; p_addr = sa; p_mask = '0; p_nacks = 0; p_due = cyc + 1;
        end else if (e_lr) begin
          pend = 1'b1; p_st = 1'b0; p_addr = la; p_mask = lm; p_rd = lr; p_data = mm[la];
          p_nacks = 0; p_due = cyc + 1;
        end
        if (bus.o_ld_rdy) lv = 1'b0;
        if (bus.o_st_rdy) sv = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
